// File: rtl/fp_normalizer_pkg.sv
// fp_normalizer_pkg: shared widths, limits and FSM encoding for the FP normalizer
package fp_normalizer_pkg;
    localparam int MANT_W = 24;
    localparam int EXP_W  = 8;
    localparam logic [EXP_W-1:0] EXP_MAX = 8'd255;
    localparam logic [EXP_W-1:0] EXP_ONE = 8'd1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;
endpackage

// File: rtl/fp_normalizer.sv
// fp_normalizer: iterative post-add/sub mantissa normalizer with valid/ready handshakes
module fp_normalizer
    import fp_normalizer_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [MANT_W:0]   i_mant_in,
    input  logic [EXP_W-1:0]  i_exp_in,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [MANT_W-1:0] o_mant_out,
    output logic [EXP_W-1:0]  o_exp_out,
    output logic [EXP_W-1:0]  o_by_out,
    output logic              o_guard_out,
    output logic              o_zero,
    output logic              o_underflow,
    output logic              o_overflow
);
    state_t            r_state, w_state_nxt;
    logic [MANT_W:0]   r_mant, w_mant_nxt;
    logic [EXP_W-1:0]  r_exp, w_exp_nxt;
    logic [EXP_W-1:0]  r_by, w_by_nxt;
    logic              r_guard, w_guard_nxt;
    logic              r_zero, w_zero_nxt;
    logic              r_uf, w_uf_nxt;
    logic              r_of, w_of_nxt;
    logic              r_out_valid, w_valid_nxt;
    logic [EXP_W-1:0]  w_exp_inc;

    assign w_exp_inc = r_exp + 1'b1;

    // Next-state and datapath update; SHIFT exits on the shift that sets the hidden bit,
    // and OUT_VALID rises one cycle after DONE is entered
    always_comb begin
        w_state_nxt = r_state;
        w_mant_nxt  = r_mant;
        w_exp_nxt   = r_exp;
        w_by_nxt    = r_by;
        w_guard_nxt = r_guard;
        w_zero_nxt  = r_zero;
        w_uf_nxt    = r_uf;
        w_of_nxt    = r_of;
        w_valid_nxt = r_out_valid;
        case (r_state)
            ST_IDLE: begin
                if (i_in_valid) begin
                    w_mant_nxt  = i_mant_in;
                    w_exp_nxt   = (i_exp_in == '0) ? EXP_ONE : i_exp_in;
                    w_by_nxt    = '0;
                    w_guard_nxt = 1'b0;
                    w_zero_nxt  = 1'b0;
                    w_uf_nxt    = 1'b0;
                    w_of_nxt    = 1'b0;
                    w_state_nxt = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (r_mant == '0) begin
                    w_zero_nxt  = 1'b1;
                    w_exp_nxt   = '0;
                    w_state_nxt = ST_DONE;
                end else if (r_mant[MANT_W]) begin
                    w_mant_nxt  = (w_exp_inc == EXP_MAX) ? '0 : {1'b0, r_mant[MANT_W:1]};
                    w_guard_nxt = r_mant[0];
                    w_exp_nxt   = w_exp_inc;
                    w_by_nxt    = '1;
                    w_of_nxt    = (w_exp_inc == EXP_MAX);
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = r_mant[MANT_W-1] ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (r_mant[MANT_W-1]) begin
                    w_state_nxt = ST_DONE;
                end else if (r_exp == EXP_ONE) begin
                    w_uf_nxt    = 1'b1;
                    w_exp_nxt   = '0;
                    w_state_nxt = ST_DONE;
                end else begin
                    w_mant_nxt  = r_mant << 1;
                    w_exp_nxt   = r_exp - 1'b1;
                    w_by_nxt    = r_by + 1'b1;
                    w_state_nxt = r_mant[MANT_W-2] ? ST_DONE : ST_SHIFT;
                end
            end
            ST_DONE: begin
                w_valid_nxt = 1'b1;
                if (r_out_valid && i_out_ready) begin
                    w_valid_nxt = 1'b0;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset discards any operand in flight
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_mant      <= '0;
            r_exp       <= '0;
            r_by        <= '0;
            r_guard     <= 1'b0;
            r_zero      <= 1'b0;
            r_uf        <= 1'b0;
            r_of        <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_mant      <= w_mant_nxt;
            r_exp       <= w_exp_nxt;
            r_by        <= w_by_nxt;
            r_guard     <= w_guard_nxt;
            r_zero      <= w_zero_nxt;
            r_uf        <= w_uf_nxt;
            r_of        <= w_of_nxt;
            r_out_valid <= w_valid_nxt;
        end
    end

    assign o_in_ready  = (r_state == ST_IDLE);
    assign o_out_valid = r_out_valid;
    assign o_mant_out  = r_out_valid ? r_mant[MANT_W-1:0] : '0;
    assign o_exp_out   = r_out_valid ? r_exp : '0;
    assign o_by_out    = r_out_valid ? r_by : '0;
    assign o_guard_out = r_out_valid & r_guard;
    assign o_zero      = r_out_valid & r_zero;
    assign o_underflow = r_out_valid & r_uf;
    assign o_overflow  = r_out_valid & r_of;
endmodule

// File: tb/tb_fp_normalizer.sv
// tb_fp_normalizer: scoreboard bench for the iterative FP normalizer
module tb_fp_normalizer;
    typedef struct {
        logic [23:0] mant;
        logic [7:0]  exp;
        logic [7:0]  by;
        logic        g, z, u, o;
        int          lat;
        int          t_acc;
    } exp_t;

    logic        clk = 0;
    logic        rst = 1;
    logic        in_valid = 0;
    logic        out_rdy = 1;
    logic [24:0] mant_in = '0;
    logic [7:0]  exp_in = '0;
    logic        o_in_ready, o_out_valid, o_guard_out, o_zero, o_underflow, o_overflow;
    logic [23:0] o_mant_out;
    logic [7:0]  o_exp_out, o_by_out;

    int   cyc = 0;
    int   n_pass = 0;
    int   n_tot = 0;
    logic prev_v = 0;
    exp_t sb[$];

    fp_normalizer dut (
        .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(o_in_ready),
        .i_mant_in(mant_in), .i_exp_in(exp_in), .o_out_valid(o_out_valid), .i_out_ready(out_rdy),
        .o_mant_out(o_mant_out), .o_exp_out(o_exp_out), .o_by_out(o_by_out), .o_guard_out(o_guard_out),
        .o_zero(o_zero), .o_underflow(o_underflow), .o_overflow(o_overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tot++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, req);
    endtask

    function automatic exp_t mk(input logic [23:0] m, input logic [7:0] e, input logic [7:0] b,
                                input logic g, input logic z, input logic u, input logic o, input int lat);
        exp_t r;
        r.mant = m; r.exp = e; r.by = b; r.g = g; r.z = z; r.u = u; r.o = o; r.lat = lat; r.t_acc = 0;
        return r;
    endfunction

    // Reference shifter: leading-one search, then shift limited by the exponent floor of 1
    function automatic exp_t model(input logic [24:0] m, input logic [7:0] e_in);
        exp_t r;
        int e, p, s;
        r = mk(24'h0, 8'h0, 8'h0, 0, 0, 0, 0, 2);
        e = (e_in == 0) ? 1 : int'(e_in);
        if (m == 0) begin
            r.z = 1;
        end else if (m[24]) begin
            r.mant = m[24:1]; r.g = m[0]; r.by = 8'hFF; r.exp = 8'(e + 1);
            if (e + 1 == 255) begin r.o = 1; r.mant = 0; end
        end else begin
            p = 0;
            for (int i = 0; i < 24; i++) if (m[i]) p = i;
            s = 23 - p;
            if (e - 1 >= s) begin
                r.mant = m[23:0] << s; r.exp = 8'(e - s); r.by = 8'(s); r.lat = 2 + s;
            end else begin
                r.mant = m[23:0] << (e - 1); r.exp = 0; r.by = 8'(e - 1); r.u = 1; r.lat = 3 + e - 1;
            end
        end
        return r;
    endfunction

    task automatic send(input logic [24:0] m, input logic [7:0] e, input exp_t x);
        int n = 0;
        @(negedge clk);
        in_valid = 1; mant_in = m; exp_in = e;
        while (!o_in_ready && n < 300) begin @(negedge clk); n++; end
        if (!o_in_ready) begin
            chk("in_ready_timeout", 0, 1);
            in_valid = 0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 0;
        x.t_acc = cyc;
        sb.push_back(x);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin @(negedge clk); n++; end
        if (sb.size() != 0) begin
            chk("drain_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_in_ready"}, o_in_ready, 1);
        chk({tag, "_out_valid"}, o_out_valid, 0);
        chk({tag, "_fields"}, {o_mant_out, o_exp_out}, 0);
        chk({tag, "_flags"}, {o_by_out, o_guard_out, o_zero, o_underflow, o_overflow}, 0);
    endtask

    // Monitor: latency on the rising edge of OUT_VALID, full result compare on each handshake
    always @(negedge clk) begin
        if (!rst) begin
            if (o_out_valid && !prev_v) begin
                if (sb.size() == 0) chk("unexpected_out", 1, 0);
                else chk("latency", cyc - sb[0].t_acc, sb[0].lat);
            end
            if (o_out_valid && out_rdy && sb.size() != 0) begin
                exp_t x;
                x = sb.pop_front();
                chk("mant_out", o_mant_out, x.mant);
                chk("exp_out", o_exp_out, x.exp);
                chk("by_out", o_by_out, x.by);
                chk("flags_gzuo", {o_guard_out, o_zero, o_underflow, o_overflow}, {x.g, x.z, x.u, x.o});
            end
        end
        prev_v <= o_out_valid;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [24:0] m;
        logic [7:0]  e;
        int n;
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        rst = 0;

        send(25'h0800000, 8'd100, mk(24'h800000, 8'd100, 8'd0, 0, 0, 0, 0, 2));
        send(25'h1000001, 8'd127, mk(24'h800000, 8'd128, 8'hFF, 1, 0, 0, 0, 2));
        send(25'h0000010, 8'd50,  mk(24'h800000, 8'd31, 8'd19, 0, 0, 0, 0, 21));
        send(25'h0000010, 8'd10,  mk(24'h002000, 8'd0, 8'd9, 0, 0, 1, 0, 12));
        send(25'h0000000, 8'd77,  mk(24'h000000, 8'd0, 8'd0, 0, 1, 0, 0, 2));
        send(25'h1000000, 8'd254, mk(24'h000000, 8'd255, 8'hFF, 0, 0, 0, 1, 2));
        send(25'h0000001, 8'd200, mk(24'h800000, 8'd177, 8'd23, 0, 0, 0, 0, 25));
        send(25'h0000010, 8'd20,  mk(24'h800000, 8'd1, 8'd19, 0, 0, 0, 0, 21));
        send(25'h0400000, 8'd0,   mk(24'h400000, 8'd0, 8'd0, 0, 0, 1, 0, 3));
        send(25'h1FFFFFE, 8'd0,   mk(24'hFFFFFF, 8'd2, 8'hFF, 0, 0, 0, 0, 2));
        drain();

        out_rdy = 0;
        send(25'h0C00000, 8'd60, mk(24'hC00000, 8'd60, 8'd0, 0, 0, 0, 0, 2));
        n = 0;
        while (!o_out_valid && n < 50) begin @(negedge clk); n++; end
        repeat (5) begin
            @(negedge clk);
            chk("hold_valid", o_out_valid, 1);
            chk("hold_in_ready", o_in_ready, 0);
            chk("hold_mant", o_mant_out, 24'hC00000);
            chk("hold_exp", o_exp_out, 8'd60);
        end
        out_rdy = 1;
        drain();

        send(25'h0000001, 8'd100, mk(24'h800000, 8'd77, 8'd23, 0, 0, 0, 0, 25));
        repeat (6) @(negedge clk);
        rst = 1;
        #1;
        chk_idle_outputs("midreset");
        sb.delete();
        @(negedge clk);
        rst = 0;
        send(25'h0000300, 8'd90, mk(24'hC00000, 8'd76, 8'd14, 0, 0, 0, 0, 16));
        drain();

        for (int k = 0; k < 16; k++) begin
            n = $urandom_range(0, 24);
            m = (25'h1 << n) | (25'($urandom) & ((25'h1 << n) - 25'h1));
            e = (k % 5 == 0) ? 8'd0 : 8'($urandom_range(1, 250));
            send(m, e, model(m, e));
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
